// File: rtl/if_id_buffer_if.sv
// Signal bundle between the fetch/control side and the IF/ID buffer.
// The slave modport is the buffer's view; master is the driver's view.
interface if_id_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              stallreq_if;

  modport master (
    output if_pc, if_inst, if_valid, stall, flush,
    input  id_pc, id_inst, id_valid, count, full, stallreq_if
  );

  modport slave (
    input  if_pc, if_inst, if_valid, stall, flush,
    output id_pc, id_inst, id_valid, count, full, stallreq_if
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline boundary: DEPTH-entry FIFO of fetched (pc, inst) pairs feeding
// a registered ID-side output, with empty-queue bypass, bubbles and flush.
module if_id_buffer #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           rst,
  if_id_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [ADDR_W-1:0] id_pc_reg, id_pc_next;
  logic [INST_W-1:0] id_inst_reg, id_inst_next;
  logic              id_valid_reg, id_valid_next;

  logic full, push, advance, pop, bypass, write_en;
  logic unused_stall_bits;

  assign unused_stall_bits = ^{bus.stall[5:3], bus.stall[0]};

  // full comes only from registered count, so IF never sees a comb path from if_*.
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign push     = bus.if_valid & ~bus.stall[1] & ~full & ~bus.flush;
  assign advance  = ~bus.stall[2] & ~bus.flush;
  assign pop      = advance & (count_reg != '0);
  assign bypass   = advance & (count_reg == '0) & push;
  assign write_en = push & ~bypass;

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    id_pc_next    = id_pc_reg;
    id_inst_next  = id_inst_reg;
    id_valid_next = id_valid_reg;

    if (bus.flush) begin
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
      id_pc_next    = '0;
      id_inst_next  = '0;
      id_valid_next = 1'b0;
    end else begin
      // Older queued entries always win over the incoming fetch to keep FIFO order.
      if (pop) begin
        id_pc_next    = pc_mem[rd_ptr_reg];
        id_inst_next  = inst_mem[rd_ptr_reg];
        id_valid_next = 1'b1;
        rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
      end else if (bypass) begin
        id_pc_next    = bus.if_pc;
        id_inst_next  = bus.if_inst;
        id_valid_next = 1'b1;
      end else if (advance) begin
        id_pc_next    = '0;
        id_inst_next  = '0;
        id_valid_next = 1'b0;
      end

      if (write_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(write_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
      id_valid_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      id_pc_reg    <= id_pc_next;
      id_inst_reg  <= id_inst_next;
      id_valid_reg <= id_valid_next;
    end
  end

  // Storage needs no reset: count/pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && write_en) begin
      pc_mem[wr_ptr_reg]   <= bus.if_pc;
      inst_mem[wr_ptr_reg] <= bus.if_inst;
    end
  end

  assign bus.id_pc       = id_pc_reg;
  assign bus.id_inst     = id_inst_reg;
  assign bus.id_valid    = id_valid_reg;
  assign bus.count       = count_reg;
  assign bus.full        = full;
  assign bus.stallreq_if = full;
endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus randomized
// traffic, all checked against a queue-based behavioural model.
module tb_if_id_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = 1 + 32 + 32 + CW + 2;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_id_buffer_if #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) bus ();

  if_id_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nmis = 0;

  ent_t        q[$];
  logic [31:0] m_pc = '0, m_inst = '0;
  logic        m_valid = 1'b0;
  bit          last_push;

  function automatic logic [VW-1:0] act_vec();
    return {bus.id_valid, bus.id_pc, bus.id_inst, bus.count, bus.full, bus.stallreq_if};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic f;
    f = (q.size() == DEPTH);
    return {m_valid, m_pc, m_inst, CW'(q.size()), f, f};
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input logic [5:0] st, input bit fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = $urandom;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  // Model step from the inputs as they stand before the edge, then advance time.
  task automatic tick();
    ent_t e, h;
    e = {bus.if_pc, bus.if_inst};
    last_push = 1'b0;
    if (rst || bus.flush) begin
      q.delete();
      m_pc = '0; m_inst = '0; m_valid = 1'b0;
    end else begin
      last_push = bus.if_valid && !bus.stall[1] && (q.size() < DEPTH);
      if (!bus.stall[2]) begin
        if (q.size() > 0) begin
          h = q.pop_front();
          m_pc = h.pc; m_inst = h.inst; m_valid = 1'b1;
          if (last_push) q.push_back(e);
        end else if (last_push) begin
          m_pc = e.pc; m_inst = e.inst; m_valid = 1'b1;
        end else begin
          m_pc = '0; m_inst = '0; m_valid = 1'b0;
        end
      end else if (last_push) begin
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 6'($urandom), 1'($urandom));
      tick();
      nvec++;
      if (act_vec() !== '0 || exp_vec() !== '0) begin
        nmis++; $display("FAIL reset[%0d] got=%h want=0", i, act_vec());
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, $urandom, 6'b0, 1'b0);
      tick();
      nvec++;
      if (bus.id_valid !== 1'b0 || act_vec() !== exp_vec()) begin
        nmis++; $display("FAIL reset_bubble[%0d] got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 6'b0, 1'b0);
      tick();
      nvec++;
      if (bus.id_pc !== 32'h100 + 32'(4 * i) || bus.id_valid !== 1'b1 || bus.count !== '0
          || act_vec() !== exp_vec()) begin
        nmis++; $display("FAIL stream[%0d] got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    drive(1'b0, '0, 6'b0, 1'b0);
    tick();
    nvec++;
    if (bus.id_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      nmis++; $display("FAIL stream_bubble got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    drive(1'b1, 32'h200, 6'b0, 1'b0);
    tick();
    for (int k = 1; k < 6; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 6'b000100, 1'b0);
      tick();
      nvec++;
      if (act_vec() !== exp_vec()) begin
        nmis++; $display("FAIL fill[%0d] got=%h want=%h", k, act_vec(), exp_vec());
      end
    end
    nvec++;
    if (bus.count !== CW'(4) || bus.full !== 1'b1 || bus.stallreq_if !== 1'b1
        || bus.id_pc !== 32'h200 || bus.id_valid !== 1'b1) begin
      nmis++; $display("FAIL fill_full got count=%0d full=%b req=%b pc=%h want 4/1/1/200",
                       bus.count, bus.full, bus.stallreq_if, bus.id_pc);
    end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, '0, 6'b0, 1'b0);
      tick();
      nvec++;
      if ((k < 5 && (bus.id_pc !== 32'h200 + 32'(4 * k) || bus.id_valid !== 1'b1))
          || (k == 5 && bus.id_valid !== 1'b0) || act_vec() !== exp_vec()) begin
        nmis++; $display("FAIL drain[%0d] got=%h want=%h", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want[3] = '{32'h3F0, 32'h3F4, 32'h300};
    drive(1'b1, 32'h3F0, 6'b000100, 1'b0); tick();
    drive(1'b1, 32'h3F4, 6'b000100, 1'b0); tick();
    nvec++;
    if (bus.count !== CW'(2)) begin
      nmis++; $display("FAIL b2b_prefill got count=%0d want 2", bus.count);
    end
    drive(1'b1, 32'h300, 6'b0, 1'b0);
    tick();
    nvec++;
    if (bus.count !== CW'(2) || bus.id_pc !== want[0] || act_vec() !== exp_vec()) begin
      nmis++; $display("FAIL b2b_pushpop got=%h want=%h", act_vec(), exp_vec());
    end
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, '0, 6'b0, 1'b0);
      tick();
      nvec++;
      if ((k < 3 && bus.id_pc !== want[k]) || (k == 3 && bus.id_valid !== 1'b0)
          || act_vec() !== exp_vec()) begin
        nmis++; $display("FAIL b2b_order[%0d] got=%h want=%h", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h3FC, 6'b0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k), 6'b000100, 1'b0); tick();
    end
    nvec++;
    if (bus.count !== CW'(3) || bus.id_valid !== 1'b1) begin
      nmis++; $display("FAIL flush_pre got count=%0d valid=%b want 3/1", bus.count, bus.id_valid);
    end
    drive(1'b1, 32'h4F0, 6'b0, 1'b1);
    tick();
    nvec++;
    if (bus.count !== '0 || bus.id_valid !== 1'b0 || bus.id_pc !== '0 || act_vec() !== exp_vec()) begin
      nmis++; $display("FAIL flush got=%h want=%h", act_vec(), exp_vec());
    end
    drive(1'b1, 32'h500, 6'b0, 1'b0);
    tick();
    nvec++;
    if (bus.id_pc !== 32'h500 || bus.id_valid !== 1'b1 || act_vec() !== exp_vec()) begin
      nmis++; $display("FAIL flush_after got=%h want=%h", act_vec(), exp_vec());
    end
    drive(1'b0, '0, 6'b0, 1'b0);
    tick();
    nvec++;
    if (bus.id_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      nmis++; $display("FAIL flush_drop got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap_random();
    logic [31:0] pushed[$];
    logic [31:0] pc_next = 32'h1000;
    logic [31:0] w;
    logic [5:0]  st;
    int accepted = 0;
    bit done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      st = 6'($urandom);
      st[1] = (q.size() == DEPTH);
      st[2] = ($urandom_range(0, 2) == 0);
      drive(accepted < 3 * DEPTH && $urandom_range(0, 3) != 0, pc_next, st, 1'b0);
      tick();
      if (last_push) begin
        pushed.push_back(pc_next);
        pc_next += 32'h4;
        accepted++;
      end
      nvec++;
      if (act_vec() !== exp_vec()) begin
        nmis++; $display("FAIL wrap_cycle[%0d] got=%h want=%h", c, act_vec(), exp_vec());
      end
      if (!st[2] && pushed.size() > 0) begin
        w = pushed.pop_front();
        nvec++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== w) begin
          nmis++; $display("FAIL wrap_order[%0d] got pc=%h v=%b want pc=%h v=1",
                           c, bus.id_pc, bus.id_valid, w);
        end
      end
      done = (accepted == 3 * DEPTH) && (pushed.size() == 0);
    end
    nvec++;
    if (!done) begin
      nmis++; $display("FAIL wrap_timeout got accepted=%0d pending=%0d want %0d/0",
                       accepted, pushed.size(), 3 * DEPTH);
    end
  endtask

  task automatic test_if_stall_bubble();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b0, '0, 6'b0, 1'b0); tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h600, 6'b000010, 1'b0);
      tick();
      nvec++;
      if (bus.id_valid !== 1'b0 || bus.id_pc !== '0 || bus.id_inst !== '0 || act_vec() !== exp_vec()) begin
        nmis++; $display("FAIL if_stall[%0d] got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    drive(1'b1, 32'h700, 6'b0, 1'b0); tick();
    drive(1'b1, 32'h704, 6'b000100, 1'b0); tick();
    drive(1'b1, 32'h708, 6'b000100, 1'b0); tick();
    rst = 1'b1;
    drive(1'b1, 32'h70C, 6'b0, 1'b0);
    tick();
    rst = 1'b0;
    nvec++;
    if (act_vec() !== '0 || exp_vec() !== '0) begin
      nmis++; $display("FAIL mid_reset got=%h want=0", act_vec());
    end
  endtask

  initial begin
    drive(1'b0, '0, 6'b0, 1'b0);
    test_reset();
    test_stream();
    test_fill();
    test_back_to_back();
    test_flush();
    test_wrap_random();
    test_if_stall_bubble();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Parametrised IF/ID pipeline boundary: a DEPTH-entry instruction queue plus registered ID-side output. Fetched (pc, inst) pairs are absorbed while ID is stalled, and IF is stalled only when the queue is full. The block inserts a bubble when ID advances with nothing to issue. It also supports a flush that discards all queued and issued-but-not-consumed instructions on branch or exception redirect.

## Interface
Parameters:
- ADDR_W, 32, width of pc fields
- INST_W, 32, width of instruction fields
- DEPTH, 4, queue entries; power of 2, >= 2

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  ADDR_W  pc of fetched instruction
- if_inst  in  INST_W  fetched instruction word
- if_valid  in  1  if_pc/if_inst hold a real fetch this cycle
- stall  in  6  control-module stall vector; stall[1] = IF stopped, stall[2] = ID stopped (1 = Stop)
- flush  in  1  discard all queued and output contents
- id_pc  out  ADDR_W  pc presented to ID
- id_inst  out  INST_W  instruction presented to ID
- id_valid  out  1  id_pc/id_inst are a real instruction (0 = bubble)
- count  out  $clog2(DEPTH+1)  queue occupancy (output register excluded)
- full  out  1  count == DEPTH
- stallreq_if  out  1  equals full; to control module, requests IF stall

## Operation
- Storage: circular array of DEPTH (pc, inst) entries; rd_ptr/wr_ptr of $clog2(DEPTH) bits wrap naturally; count register tracks occupancy.
- Push condition: if_valid & stall[1]==0 & ~full & ~flush, where full is computed from the registered count.
- Advance condition: stall[2]==0 & ~flush. On advance, the output register loads one of the following, in priority order:
  - the queue head, if count>0 (rd_ptr++, count--);
  - otherwise the incoming entry, if push is true (bypass; entry is not written to the queue);
  - otherwise a bubble: id_pc=0, id_inst=0, id_valid=0.
- If push is true and the incoming entry was not consumed by bypass, it is written at wr_ptr (wr_ptr++, count++).
- Simultaneous pop and push with count>0: count is unchanged and both pointers advance.
- stall[2]==1 and no flush: output register holds its value and id_valid is unchanged.
- Flush (dominates everything except rst): next cycle count=0, rd_ptr=wr_ptr=0, id_pc=0, id_inst=0, id_valid=0. The if_* input in the flush cycle is dropped.
- When full, pushes are blocked even if a pop occurs in the same cycle. The entry is not lost, because stallreq_if=1 causes the control module to assert stall[1].
- stall[3..5] and stall[0] are ignored.

## Timing
- Reset (rst=1 at an edge): id_pc=0, id_inst=0, id_valid=0, count=0, full=0, stallreq_if=0, pointers 0. Reset dominates flush and stall. Reset asserted mid-operation discards all contents in one cycle.
- Latency: with the queue empty and ID advancing, an if_* entry pushed in cycle N appears on id_* after edge N (1 cycle), identical to a plain IF/ID register.
- With the queue non-empty, each entry waits one extra cycle per older entry ahead of it. Order is strictly FIFO.
- count, full and stallreq_if are registered-state derived, with no combinational path from the if_* inputs.
- Data outputs are registered; the only input-to-output path is through the bypass, and it is sampled at the clock edge.

## Test plan
- Reset: drive junk inputs with rst=1 for 2 cycles -> all outputs 0. Release rst, if_valid=0, stall=0 -> id_valid stays 0 (bubbles).
- Streaming bypass: stall=0; push pc 0x100, 0x104, 0x108 on consecutive cycles -> id_pc = 0x100, 0x104, 0x108 one cycle later each, id_valid=1, count stays 0.
- Fill under ID stall (DEPTH=4): stall=6'b000100; push 0x200..0x214 (6 attempts) -> output register takes 0x200, queue holds 0x204..0x210, count=4, full=1, stallreq_if=1. The 0x214 push is blocked. Release stall[2] -> id_pc = 0x204, 0x208, 0x20C, 0x210 in order, then bubble.
- Simultaneous push/pop at count=2: push 0x300 while ID advances -> count stays 2 and head issues. 0x300 issues after the two older entries.
- Flush: count=3, id_valid=1, assert flush for 1 cycle with if_valid=1 -> next cycle count=0, id_valid=0, id_pc=0. The flush-cycle fetch is never issued, and the next fetch issues normally.
- Pointer wrap / IF-stall bubble: run 3×DEPTH pushes and pops with random stall[2] -> issued pc sequence equals pushed sequence. stall[1]=1 with stall[2]=0 and empty queue -> id_valid=0 with zeros.
